// File: rtl/lsu_mem_stage.sv
// Memory stage of the load/store unit: latches one entry, issues an aligned
// memory request with req/gnt + rvalid handshakes, and extends load data for writeback.
module lsu_mem_stage #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS),
    parameter int ADDR_SIZE = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_SIZE-1:0]     result,
    input  logic [WORD_SIZE-1:0]     save_data,
    input  logic [REG_SEL-1:0]       rd,
    input  logic                     reg_write,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic                     data_sign,
    input  logic [1:0]               data_size,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_SIZE-1:0]     mem_addr,
    output logic [WORD_SIZE/8-1:0]   mem_be,
    output logic [WORD_SIZE-1:0]     mem_wdata,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [WORD_SIZE-1:0]     mem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     reg_write_out,
    output logic [REG_SEL-1:0]       rd_out,
    output logic [WORD_SIZE-1:0]     read_data,
    output logic [WORD_SIZE-1:0]     result_out,
    output logic                     misalign
);

    localparam int OFF = $clog2(WORD_SIZE/8);
    localparam int BE  = WORD_SIZE/8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    // Only the store flag is kept: a store wins when both read and write are set.
    typedef struct packed {
        logic [WORD_SIZE-1:0] result;
        logic [WORD_SIZE-1:0] save_data;
        logic [REG_SEL-1:0]   rd;
        logic                 reg_write;
        logic                 mem_write;
        logic                 data_sign;
        logic [1:0]           data_size;
    } entry_t;

    state_t state, state_nx;
    entry_t ent;
    logic   mis_q;

    function automatic logic is_misaligned(input logic [OFF-1:0] lane, input logic [1:0] size);
        logic bad;
        bad = 1'b0;
        case (size)
            2'b01:   bad = lane[0];
            2'b10:   bad = (lane[1:0] != 2'b00);
            2'b11:   bad = (WORD_SIZE == 32) || (lane != '0);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    logic accept, in_mem, in_mis;
    logic done_now, done_store, done_load;
    logic [OFF-1:0] lane;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign in_mem   = mem_read || mem_write;
    assign in_mis   = in_mem && is_misaligned(result[OFF-1:0], data_size);

    assign done_now   = accept && (!in_mem || in_mis);
    assign done_store = (state == REQ) && mem_gnt && ent.mem_write;
    assign done_load  = (state == WAIT) && mem_rvalid;

    assign lane = ent.result[OFF-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && in_mem && !in_mis) state_nx = REQ;
            REQ:     if (mem_gnt) state_nx = ent.mem_write ? IDLE : WAIT;
            WAIT:    if (mem_rvalid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Byte-enable mask and lane-aligned request fields, driven only while requesting.
    logic [BE-1:0] be_mask;
    always_comb begin
        be_mask = '0;
        case (ent.data_size)
            2'b00:   be_mask = BE'(8'h01);
            2'b01:   be_mask = BE'(8'h03);
            2'b10:   be_mask = BE'(8'h0F);
            default: be_mask = '1;
        endcase
    end

    assign mem_req   = (state == REQ);
    assign mem_we    = mem_req && ent.mem_write;
    assign mem_addr  = mem_req ? ent.result[ADDR_SIZE+OFF-1:OFF] : '0;
    assign mem_be    = mem_req ? BE'(be_mask << lane) : '0;
    assign mem_wdata = mem_req ? (ent.save_data << {lane, 3'b000}) : '0;

    // data_sign=0 means sign-extend; size casts of signed slices perform the extension.
    logic [WORD_SIZE-1:0] rd_sh, ld_ext;
    assign rd_sh = mem_rdata >> {lane, 3'b000};
    always_comb begin
        ld_ext = rd_sh;
        case (ent.data_size)
            2'b00:   ld_ext = ent.data_sign ? WORD_SIZE'(rd_sh[7:0])  : WORD_SIZE'($signed(rd_sh[7:0]));
            2'b01:   ld_ext = ent.data_sign ? WORD_SIZE'(rd_sh[15:0]) : WORD_SIZE'($signed(rd_sh[15:0]));
            2'b10:   ld_ext = ent.data_sign ? WORD_SIZE'(rd_sh[31:0]) : WORD_SIZE'($signed(rd_sh[31:0]));
            default: ld_ext = rd_sh;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent       <= '0;
            mis_q     <= 1'b0;
            out_valid <= 1'b0;
            read_data <= '0;
        end else begin
            if (accept) begin
                ent <= '{result: result, save_data: save_data, rd: rd,
                         reg_write: reg_write, mem_write: mem_write,
                         data_sign: data_sign, data_size: data_size};
                mis_q <= in_mis;
            end
            if (done_now || done_store || done_load) out_valid <= 1'b1;
            else if (out_ready)                      out_valid <= 1'b0;
            if (done_now || done_store) read_data <= '0;
            else if (done_load)         read_data <= ld_ext;
        end
    end

    assign reg_write_out = ent.reg_write && !mis_q;
    assign rd_out        = ent.rd;
    assign result_out    = ent.result;
    assign misalign      = mis_q;

endmodule
